// File: rtl/exmem_skid_pkg.sv
// exmem_skid_pkg: shared RISC-V pipeline types (package riscv_types) for the EX/MEM skid buffer
//   riscv_control_t  control bits carried from EX into MEM/WB
//   exmem_state_t    skid occupancy: EMPTY, ONE (main only), FULL (main + skid)
//   exmem_payload_t  one EX/MEM entry at the default widths (XLEN, REG_W)
package riscv_types;
  localparam int XLEN = 32;
  localparam int REG_W = 5;
  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       alu_src;
    logic [1:0] alu_op;
  } riscv_control_t;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} exmem_state_t;
  typedef struct packed {
    logic             zero;
    logic [XLEN-1:0]  pc_branch;
    logic [XLEN-1:0]  alu_res;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  drs2;
    riscv_control_t   ctrl;
  } exmem_payload_t;
endpackage

// File: rtl/exmem_skid_sat_counter.sv
// sat_counter: event counter that sticks at all-ones
//   clk_in  clock, rst_in async active-high reset
//   inc     count this cycle
//   count   current value, saturating
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) count <= '0;
    else if (inc && !(&count)) count <= count + CNT_W'(1);
endmodule

// File: rtl/exmem_skid.sv
// exmem_skid: two-entry EX/MEM pipeline register with skid slot and registered up-ready
//   clk_in, rst_in (async active-high), flush_in (sync kill of all entries)
//   up_valid_in/up_ready_out + EX payload inputs: accept side
//   dn_valid_out/dn_ready_in + MEM payload outputs: drain side, zeroed when not valid
//   stall_cnt_out, flush_cnt_out: saturating perf counters, only with EXMEM_PERF_EN defined
module exmem_skid
  import riscv_types::*;
#(
  parameter int WIDTH = 32,
  parameter int INDEX = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             flush_in,
  input  logic             up_valid_in,
  output logic             up_ready_out,
  input  logic             zero_in,
  input  logic [WIDTH-1:0] pc_branch_in,
  input  logic [WIDTH-1:0] alu_res_in,
  input  logic [INDEX-1:0] rd_in,
  input  logic [WIDTH-1:0] drs2_in,
  input  riscv_control_t   ctrl_vector_in,
  output logic             dn_valid_out,
  input  logic             dn_ready_in,
  output logic             zero_out,
  output logic [WIDTH-1:0] pc_branch_out,
  output logic [WIDTH-1:0] alu_res_out,
  output logic [INDEX-1:0] rd_out,
  output logic [WIDTH-1:0] drs2_out,
  output riscv_control_t   ctrl_vector_out
`ifdef EXMEM_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt_out,
  output logic [CNT_W-1:0] flush_cnt_out
`endif
);
  // entries are stored flat so WIDTH/INDEX stay free; field order matches exmem_payload_t
  localparam int PW = 1 + 3 * WIDTH + INDEX + $bits(riscv_control_t);
  exmem_state_t state_q, state_d;
  logic [PW-1:0] in_pl, main_q, main_d, skid_q, skid_d, out_pl;
  logic ready_q, acc, drn;
  assign in_pl = {zero_in, pc_branch_in, alu_res_in, rd_in, drs2_in, ctrl_vector_in};
  assign dn_valid_out = state_q != EMPTY;
  assign up_ready_out = ready_q;
  assign acc = up_valid_in && ready_q;
  assign drn = dn_valid_out && dn_ready_in;
  assign out_pl = dn_valid_out ? main_q : '0;
  assign {zero_out, pc_branch_out, alu_res_out, rd_out, drs2_out, ctrl_vector_out} = out_pl;
  always_comb begin
    state_d = state_q;
    main_d = main_q;
    skid_d = skid_q;
    if (flush_in) begin
      state_d = EMPTY;
      main_d = '0;
      skid_d = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          state_d = acc ? ONE : EMPTY;
          main_d = acc ? in_pl : main_q;
        end
        ONE: begin
          state_d = (acc && !drn) ? FULL : (drn && !acc) ? EMPTY : ONE;
          main_d = (acc && drn) ? in_pl : main_q;
          skid_d = (acc && !drn) ? in_pl : skid_q;
        end
        FULL: begin
          state_d = drn ? ONE : FULL;
          main_d = drn ? skid_q : main_q;
        end
        default: state_d = EMPTY;
      endcase
    end
  end
  // ready is registered from the next state, so dn_ready_in never reaches up_ready_out combinationally
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      state_q <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q <= main_d;
      skid_q <= skid_d;
      ready_q <= state_d != FULL;
    end
`ifdef EXMEM_PERF_EN
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .inc(dn_valid_out && !dn_ready_in),
    .count(stall_cnt_out)
  );
  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .inc(flush_in && state_q != EMPTY),
    .count(flush_cnt_out)
  );
`endif
endmodule

// File: tb/tb_exmem_skid.sv
// tb_exmem_skid: randomized + directed scoreboard bench for exmem_skid against a FIFO model
module tb_exmem_skid;
  import riscv_types::*;
`ifdef EXMEM_PERF_EN
  localparam int CW = 4;
`else
  localparam int CW = 16;
`endif
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0;
  logic rst_in = 1'b1;
  logic flush_in = 1'b0;
  logic up_valid_in = 1'b0;
  logic dn_ready_in = 1'b0;
  logic up_ready_out, dn_valid_out;
  exmem_payload_t din = '0;
  exmem_payload_t dout;
  logic zo;
  logic [31:0] pco, alo, d2o;
  logic [4:0] rdo;
  riscv_control_t cto;
`ifdef EXMEM_PERF_EN
  logic [CW-1:0] stall_cnt, flush_cnt;
`endif
  exmem_payload_t q[$];
  bit ready_m = 1'b0;
  int stall_m = 0;
  int flush_m = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exmem_skid #(.WIDTH(32), .INDEX(5), .CNT_W(CW)) dut (
    .clk_in(clk),
    .rst_in(rst_in),
    .flush_in(flush_in),
    .up_valid_in(up_valid_in),
    .up_ready_out(up_ready_out),
    .zero_in(din.zero),
    .pc_branch_in(din.pc_branch),
    .alu_res_in(din.alu_res),
    .rd_in(din.rd),
    .drs2_in(din.drs2),
    .ctrl_vector_in(din.ctrl),
    .dn_valid_out(dn_valid_out),
    .dn_ready_in(dn_ready_in),
    .zero_out(zo),
    .pc_branch_out(pco),
    .alu_res_out(alo),
    .rd_out(rdo),
    .drs2_out(d2o),
    .ctrl_vector_out(cto)
`ifdef EXMEM_PERF_EN
    ,
    .stall_cnt_out(stall_cnt),
    .flush_cnt_out(flush_cnt)
`endif
  );

  assign dout = '{zero: zo, pc_branch: pco, alu_res: alo, rd: rdo, drs2: d2o, ctrl: cto};

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  function automatic exmem_payload_t rnd_pl();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return exmem_payload_t'(r[$bits(exmem_payload_t)-1:0]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference: an in-order queue of at most two entries; ready means fewer than two were held at the last edge
  always @(posedge clk)
    if (rst_in) begin
      q.delete();
      ready_m = 1'b0;
      stall_m = 0;
      flush_m = 0;
    end else begin
      if (q.size() > 0 && !dn_ready_in && stall_m < CMAX) stall_m++;
      if (flush_in && q.size() > 0 && flush_m < CMAX) flush_m++;
      if (flush_in) q.delete();
      else begin
        if (q.size() > 0 && dn_ready_in) void'(q.pop_front());
        if (up_valid_in && ready_m) q.push_back(din);
      end
      ready_m = q.size() < 2;
    end

  always @(negedge clk) begin
    chk("dn_valid", 128'(dn_valid_out), 128'(q.size() > 0));
    chk("up_ready", 128'(up_ready_out), 128'(ready_m));
    if (q.size() > 0) chk("payload", 128'(dout), 128'(q[0]));
    else chk("bubble", 128'(dout), 128'(0));
`ifdef EXMEM_PERF_EN
    chk("stall_cnt", 128'(stall_cnt), 128'(stall_m));
    chk("flush_cnt", 128'(flush_cnt), 128'(flush_m));
`endif
  end

  initial begin
    repeat (3) tick();
    rst_in = 1'b0;
    chk("ready_before_edge", 128'(up_ready_out), 128'(0));
    tick();
    chk("ready_after_release", 128'(up_ready_out), 128'(1));
    din = '0;
    din.alu_res = 32'h0000_1234;
    din.rd = 5'd5;
    up_valid_in = 1'b1;
    dn_ready_in = 1'b1;
    chk("lat_pre_valid", 128'(dn_valid_out), 128'(0));
    tick();
    up_valid_in = 1'b0;
    chk("lat_valid", 128'(dn_valid_out), 128'(1));
    chk("lat_alu", 128'(alo), 128'(32'h1234));
    chk("lat_rd", 128'(rdo), 128'(5));
    tick();
    for (int i = 0; i < 8; i++) begin
      din = rnd_pl();
      up_valid_in = 1'b1;
      tick();
      chk("stream_ready", 128'(up_ready_out), 128'(1));
      chk("stream_valid", 128'(dn_valid_out), 128'(1));
    end
    up_valid_in = 1'b0;
    repeat (2) tick();
    dn_ready_in = 1'b0;
    din = '0;
    din.alu_res = 32'hA;
    up_valid_in = 1'b1;
    tick();
    din.alu_res = 32'hB;
    tick();
    chk("full_ready", 128'(up_ready_out), 128'(0));
    din.alu_res = 32'hC;
    repeat (20) tick();
    chk("hold_ready", 128'(up_ready_out), 128'(0));
    chk("hold_alu", 128'(alo), 128'(32'hA));
`ifdef EXMEM_PERF_EN
    chk("stall_sat", 128'(stall_cnt), 128'(4'hF));
`endif
    dn_ready_in = 1'b1;
    tick();
    chk("drain_b", 128'(alo), 128'(32'hB));
    tick();
    up_valid_in = 1'b0;
    chk("drain_c", 128'(alo), 128'(32'hC));
    tick();
    dn_ready_in = 1'b0;
    up_valid_in = 1'b1;
    din = rnd_pl();
    tick();
    din = rnd_pl();
    tick();
    din = rnd_pl();
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    up_valid_in = 1'b0;
    chk("flush_full_valid", 128'(dn_valid_out), 128'(0));
    chk("flush_full_alu", 128'(alo), 128'(0));
    chk("flush_full_ready", 128'(up_ready_out), 128'(1));
    dn_ready_in = 1'b1;
    repeat (3) tick();
    up_valid_in = 1'b1;
    din = rnd_pl();
    tick();
    din = rnd_pl();
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    up_valid_in = 1'b0;
    chk("flush_one_valid", 128'(dn_valid_out), 128'(0));
    tick();
    for (int i = 0; i < 400; i++) begin
      din = rnd_pl();
      up_valid_in = $urandom_range(0, 3) != 0;
      dn_ready_in = $urandom_range(0, 3) != 0;
      flush_in = $urandom_range(0, 31) == 0;
      tick();
    end
    flush_in = 1'b0;
    dn_ready_in = 1'b0;
    up_valid_in = 1'b1;
    din = rnd_pl();
    tick();
    din = rnd_pl();
    tick();
    @(posedge clk);
    #2;
    rst_in = 1'b1;
    q.delete();
    ready_m = 1'b0;
    stall_m = 0;
    flush_m = 0;
    #1;
    chk("async_valid", 128'(dn_valid_out), 128'(0));
    chk("async_ready", 128'(up_ready_out), 128'(0));
    chk("async_alu", 128'(alo), 128'(0));
    chk("async_pc", 128'(pco), 128'(0));
    up_valid_in = 1'b0;
    dn_ready_in = 1'b1;
    repeat (2) tick();
    rst_in = 1'b0;
    repeat (4) tick();
    chk("post_reset_empty", 128'(dn_valid_out), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/exmem_skid.md
EXMEM_SKID -- requirements
Module: exmem_skid

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data/address field width.
REQ-002 SHALL have parameter INDEX, default 5, meaning register-index width.
REQ-003 SHALL have parameter CNT_W, default 16, meaning perf-counter width.
REQ-004 SHALL have port clk_in  input  1  meaning sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_in  input  1  meaning asynchronous, active-high reset.
REQ-006 SHALL have port flush_in  input  1  meaning synchronous kill of all held entries.
REQ-007 SHALL have port up_valid_in  input  1  meaning EX offers a payload.
REQ-008 SHALL have port up_ready_out  output  1  meaning block accepts a payload this cycle.
REQ-009 SHALL have payload inputs zero_in 1, pc_branch_in WIDTH, alu_res_in WIDTH, rd_in INDEX, drs2_in WIDTH, ctrl_vector_in riscv_control_t.
REQ-010 SHALL have port dn_valid_out  output  1  meaning MEM-side payload valid.
REQ-011 SHALL have port dn_ready_in  input  1  meaning MEM consumes the payload this cycle.
REQ-012 SHALL have payload outputs zero_out, pc_branch_out, alu_res_out, rd_out, drs2_out, ctrl_vector_out, matching the input widths.
REQ-013 SHALL have ports stall_cnt_out and flush_cnt_out, output, CNT_W, present only under EXMEM_PERF_EN.

Function
REQ-014 SHALL hold two entries, main (drives outputs) and skid, giving states EMPTY, ONE and FULL.
REQ-015 SHALL accept on up_valid_in && up_ready_out and drain on dn_valid_out && dn_ready_in.
REQ-016 SHALL drive up_ready_out = (state != FULL) from a register, with no combinational path from dn_ready_in.
REQ-017 SHALL move EMPTY->ONE on accept, with dn_valid_out high the next cycle (1-cycle latency).
REQ-018 SHALL, in ONE: stay ONE on accept+drain (main reloads with new payload); go ONE->EMPTY on drain only; go ONE->FULL on accept only (new payload into skid).
REQ-019 SHALL, in FULL: move skid to main and go FULL->ONE on drain; otherwise hold.
REQ-020 SHALL deliver payloads strictly in acceptance order, sustaining one per cycle when dn_ready_in is held high.
REQ-021 SHALL, on flush_in, go to EMPTY next cycle, discarding main, skid and any same-cycle accept; flush overrides accept and drain.
REQ-022 SHALL drive all payload outputs to zero (bubble/NOP) whenever dn_valid_out is low.
REQ-023 SHALL keep payload outputs stable while dn_valid_out && !dn_ready_in.

Reset
REQ-024 SHALL, while rst_in is high, asynchronously force state EMPTY, dn_valid_out 0, up_ready_out 0, all payload outputs 0 and counters 0.
REQ-025 SHALL raise up_ready_out on the first rising clk_in edge after rst_in falls.
REQ-026 SHALL, on reset asserted mid-transfer, lose all held entries and not deliver them after reset.

Configuration
REQ-027 SHALL, with EXMEM_PERF_EN defined, count stall_cnt_out on cycles with dn_valid_out && !dn_ready_in, and flush_cnt_out on cycles with flush_in && state != EMPTY.
REQ-028 SHALL saturate both counters at all-ones.
REQ-029 SHALL, without EXMEM_PERF_EN, omit both counter ports and all counter logic.

Structure
REQ-030 SHALL take riscv_control_t from riscv_types, and SHALL add exmem_state_t (EMPTY, ONE, FULL) and an exmem_payload_t struct to that package.
REQ-031 SHALL instantiate one sub-module, sat_counter (parameter CNT_W, inputs clk_in, rst_in, inc), twice under EXMEM_PERF_EN.

Verification
REQ-032 SHALL cover reset release, then alu_res_in=32'h0000_1234, rd_in=5 with dn_ready_in=1 -> dn_valid_out=1 and alu_res_out=32'h1234, rd_out=5 exactly one cycle later.
REQ-033 SHALL cover streaming 8 payloads with dn_ready_in=1 -> 8 outputs in order, one per cycle, up_ready_out never 0.
REQ-034 SHALL cover dn_ready_in=0 and offering A=32'hA, B=32'hB, C=32'hC -> up_ready_out=0 after B and C held; releasing dn_ready_in -> A then B, with C accepted once ready.
REQ-035 SHALL cover flush_in pulsed in FULL with a same-cycle accept -> next cycle dn_valid_out=0, outputs 0, up_ready_out=1, no flushed payload ever appears.
REQ-036 SHALL cover rst_in asserted mid-stream, asynchronously between clock edges -> outputs 0 immediately, state EMPTY.
REQ-037 SHALL cover, with EXMEM_PERF_EN and CNT_W=4, 20 stall cycles -> stall_cnt_out=4'hF.
